// File: rtl/pid_controller.sv
// -----------------------------------------------------------------------------
// pid_controller
//
// Discrete-time signed fixed-point PID controller with a registered output.
// Each qualified clock computes one iteration on e = target - measurement:
//   integ_next = sat(integ + e)
//   d          = sat(e - e_prev)
//   acc        = Kp*e + Ki*integ_next + Kd*d
//   y          = (acc >>> FRAC_BITS) + bias
// and registers y into out_clocked. The integrator and the previous error are
// kept as state.
//
// Gains (Kp, Ki, Kd) and the output bias are loaded through an active-low
// write strobe. These registers are not touched by reset. They power up at
// zero through their declaration initialisers.
//
// Build option:
//   PID_OUT_SATURATE_EN  defined   -> y is clamped to the D_WIDTH signed range
//                        undefined -> y keeps its low D_WIDTH bits (wraps)
//
// Parameters:
//   D_WIDTH    width of data, gains, target, measurement and output (signed)
//   FRAC_BITS  fractional bits of the gain format (1 << FRAC_BITS == 1.0)
//
// Ports:
//   clock           system clock, rising-edge active
//   reset           asynchronous active-low reset of integ, e_prev, out_clocked
//   write_enable    active-low register write strobe (blocks iteration)
//   iterate_enable  active-high, one PID iteration per qualified clock
//   reg_addr        register address: 0 Kp, 1 Ki, 2 Kd, 3 bias, other ignored
//   reg_data        signed register write data
//   target          signed setpoint
//   measurement     signed process feedback
//   out_clocked     signed registered controller output
// -----------------------------------------------------------------------------
module pid_controller #(
    parameter int D_WIDTH   = 32,
    parameter int FRAC_BITS = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      write_enable,
    input  logic                      iterate_enable,
    input  logic        [D_WIDTH-1:0] reg_addr,
    input  logic signed [D_WIDTH-1:0] reg_data,
    input  logic signed [D_WIDTH-1:0] target,
    input  logic signed [D_WIDTH-1:0] measurement,
    output logic signed [D_WIDTH-1:0] out_clocked
);

    // Product, accumulator and biased-output widths. The accumulator carries
    // two guard bits for the three-term sum, and the biased output carries
    // one more for the bias addition, so nothing overflows before the final
    // reduction to D_WIDTH.
    localparam int PW = 2 * D_WIDTH;
    localparam int AW = PW + 2;
    localparam int YW = AW + 1;

    localparam logic signed [D_WIDTH-1:0] SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH-1:0] SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    localparam logic [D_WIDTH-1:0] ADDR_KP   = D_WIDTH'(0);
    localparam logic [D_WIDTH-1:0] ADDR_KI   = D_WIDTH'(1);
    localparam logic [D_WIDTH-1:0] ADDR_KD   = D_WIDTH'(2);
    localparam logic [D_WIDTH-1:0] ADDR_BIAS = D_WIDTH'(3);

    // -------------------------------------------------------------------------
    // Sign extension and saturation helpers
    // -------------------------------------------------------------------------
    function automatic logic signed [D_WIDTH:0] sext1(input logic signed [D_WIDTH-1:0] v);
        return $signed({v[D_WIDTH-1], v});
    endfunction

    function automatic logic signed [PW-1:0] sext_p(input logic signed [D_WIDTH-1:0] v);
        return $signed({{D_WIDTH{v[D_WIDTH-1]}}, v});
    endfunction

    function automatic logic signed [AW-1:0] sext_a(input logic signed [PW-1:0] v);
        return $signed({{2{v[PW-1]}}, v});
    endfunction

    function automatic logic signed [YW-1:0] sext_y(input logic signed [D_WIDTH-1:0] v);
        return $signed({{(YW-D_WIDTH){v[D_WIDTH-1]}}, v});
    endfunction

    // Clamp a D_WIDTH+1 bit value: overflow shows up as a disagreement
    // between the two top bits, the top bit giving the direction.
    function automatic logic signed [D_WIDTH-1:0] sat_d1(input logic signed [D_WIDTH:0] v);
        logic signed [D_WIDTH-1:0] r;
        if (v[D_WIDTH] != v[D_WIDTH-1]) begin
            r = v[D_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            r = v[D_WIDTH-1:0];
        end
        return r;
    endfunction

`ifdef PID_OUT_SATURATE_EN
    localparam logic signed [YW-1:0] Y_MAX = {{(YW-D_WIDTH){1'b0}}, SAT_MAX};
    localparam logic signed [YW-1:0] Y_MIN = {{(YW-D_WIDTH){1'b1}}, SAT_MIN};

    // Clamp the full-width biased output to the D_WIDTH signed range.
    function automatic logic signed [D_WIDTH-1:0] sat_y(input logic signed [YW-1:0] v);
        logic signed [D_WIDTH-1:0] r;
        if (v > Y_MAX) begin
            r = SAT_MAX;
        end else if (v < Y_MIN) begin
            r = SAT_MIN;
        end else begin
            r = v[D_WIDTH-1:0];
        end
        return r;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Gain and bias registers
    // -------------------------------------------------------------------------
    // Deliberately outside the reset domain so a controller reset does not
    // lose its tuning.
    logic signed [D_WIDTH-1:0] kp   = '0;
    logic signed [D_WIDTH-1:0] ki   = '0;
    logic signed [D_WIDTH-1:0] kd   = '0;
    logic signed [D_WIDTH-1:0] bias = '0;

    always_ff @(posedge clock) begin
        if (!write_enable) begin
            case (reg_addr)
                ADDR_KP:   kp   <= reg_data;
                ADDR_KI:   ki   <= reg_data;
                ADDR_KD:   kd   <= reg_data;
                ADDR_BIAS: bias <= reg_data;
                default:   ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stage p0: combinational PID iteration on the current inputs
    // -------------------------------------------------------------------------
    logic signed [D_WIDTH-1:0] integ;
    logic signed [D_WIDTH-1:0] e_prev;

    logic                      vld_p0;
    logic signed [D_WIDTH:0]   e_wide_p0;
    logic signed [D_WIDTH-1:0] e_p0;
    logic signed [D_WIDTH-1:0] integ_next_p0;
    logic signed [D_WIDTH-1:0] d_p0;
    logic signed [PW-1:0]      prod_p_p0;
    logic signed [PW-1:0]      prod_i_p0;
    logic signed [PW-1:0]      prod_d_p0;
    logic signed [AW-1:0]      acc_p0;
    logic signed [AW-1:0]      acc_sh_p0;
    logic signed [YW-1:0]      y_p0;
    logic signed [D_WIDTH-1:0] out_next_p0;

    // A write cycle always wins over an iteration request.
    assign vld_p0 = write_enable & iterate_enable;

    assign e_wide_p0     = sext1(target) - sext1(measurement);
    assign e_p0          = sat_d1(e_wide_p0);
    assign integ_next_p0 = sat_d1(sext1(integ) + sext1(e_p0));
    assign d_p0          = sat_d1(sext1(e_p0) - sext1(e_prev));

    // Operands are widened to the product width first, so each multiply is a
    // full 2*D_WIDTH signed product with no loss.
    assign prod_p_p0 = sext_p(kp) * sext_p(e_p0);
    assign prod_i_p0 = sext_p(ki) * sext_p(integ_next_p0);
    assign prod_d_p0 = sext_p(kd) * sext_p(d_p0);

    assign acc_p0    = sext_a(prod_p_p0) + sext_a(prod_i_p0) + sext_a(prod_d_p0);

    // Arithmetic shift drops the gain fraction, rounding toward -inf.
    assign acc_sh_p0 = acc_p0 >>> FRAC_BITS;
    assign y_p0      = $signed({acc_sh_p0[AW-1], acc_sh_p0}) + sext_y(bias);

`ifdef PID_OUT_SATURATE_EN
    assign out_next_p0 = sat_y(y_p0);
`else
    assign out_next_p0 = D_WIDTH'(y_p0);
`endif

    // -------------------------------------------------------------------------
    // Stage p1: registered controller state and output
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            integ       <= '0;
            e_prev      <= '0;
            out_clocked <= '0;
        end else if (vld_p0) begin
            integ       <= integ_next_p0;
            e_prev      <= e_p0;
            out_clocked <= out_next_p0;
        end
    end

endmodule

// File: tb/tb_pid_controller.sv
// -----------------------------------------------------------------------------
// tb_pid_controller
//
// Directed-vector bench for pid_controller (D_WIDTH=32, FRAC_BITS=15).
// Stimulus tasks drive inputs on the falling edge and push the hand-computed
// expected output into a queue. A monitor process samples shortly after each
// rising edge at which a checked operation was presented and compares the
// registered output against the head of the queue.
// -----------------------------------------------------------------------------
module tb_pid_controller;

    localparam logic signed [31:0] MAXV = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MINV = 32'sh8000_0000;
    localparam logic signed [31:0] ONE  = 32'sd32768;

    logic               clock;
    logic               reset;
    logic               write_enable;
    logic               iterate_enable;
    logic        [31:0] reg_addr;
    logic signed [31:0] reg_data;
    logic signed [31:0] target;
    logic signed [31:0] measurement;
    logic signed [31:0] out_clocked;

    typedef struct {
        string              name;
        logic signed [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req;
    int   checks;
    int   errors;

    pid_controller #(
        .D_WIDTH  (32),
        .FRAC_BITS(15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .write_enable  (write_enable),
        .iterate_enable(iterate_enable),
        .reg_addr      (reg_addr),
        .reg_data      (reg_data),
        .target        (target),
        .measurement   (measurement),
        .out_clocked   (out_clocked)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Direct comparison, used where no clock edge is involved.
    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     nm, act, act, ex, ex);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic signed [31:0] dv);
        @(negedge clock);
        write_enable   = 1'b0;
        iterate_enable = 1'b0;
        reg_addr       = a;
        reg_data       = dv;
        chk_req        = 1'b0;
    endtask

    task automatic it(input string nm, input logic signed [31:0] t,
                      input logic signed [31:0] m, input logic signed [31:0] ex);
        exp_t x;
        @(negedge clock);
        write_enable   = 1'b1;
        iterate_enable = 1'b1;
        target         = t;
        measurement    = m;
        chk_req        = 1'b1;
        x.name = nm;
        x.val  = ex;
        exp_q.push_back(x);
    endtask

    // A cycle that must not iterate; the write goes to an unmapped address.
    task automatic hold(input string nm, input logic we, input logic ie,
                        input logic signed [31:0] m, input logic signed [31:0] ex);
        exp_t x;
        @(negedge clock);
        write_enable   = we;
        iterate_enable = ie;
        reg_addr       = 32'd7;
        reg_data       = 32'sh0000_1234;
        measurement    = m;
        chk_req        = 1'b1;
        x.name = nm;
        x.val  = ex;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        @(negedge clock);
        write_enable   = 1'b1;
        iterate_enable = 1'b0;
        chk_req        = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clock);
        write_enable   = 1'b1;
        iterate_enable = 1'b0;
        chk_req        = 1'b0;
        reset          = 1'b0;
        @(negedge clock);
        reset          = 1'b1;
    endtask

    // Monitor: an operation presented at a rising edge is checked 2 time
    // units later against the oldest queued expectation.
    initial begin
        logic req;
        exp_t x;
        forever begin
            @(posedge clock);
            req = chk_req;
            #2;
            if (req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %0d, expected no pending item",
                             out_clocked);
                end else begin
                    x = exp_q.pop_front();
                    if (out_clocked !== x.val) begin
                        errors++;
                        $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                                 x.name, out_clocked, out_clocked, x.val, x.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        chk_req        = 1'b0;
        reset          = 1'b1;
        write_enable   = 1'b1;
        iterate_enable = 1'b0;
        reg_addr       = '0;
        reg_data       = '0;
        target         = '0;
        measurement    = '0;

        #3 reset = 1'b0;
        #1 check("reset_state", out_clocked, 32'sd0);
        @(negedge clock);
        reset = 1'b1;

        // Kp = Ki = 1.0, closed loop measurement += out_clocked.
        wr(32'd0, ONE);
        wr(32'd1, ONE);
        wr(32'd2, 32'sd0);
        wr(32'd3, 32'sd0);
        rst_pulse();
        it("loop_iter1", 32'sd32768, 32'sd65536, -32'sd65536);
        it("loop_iter2", 32'sd32768, 32'sd0,      32'sd32768);
        it("loop_iter3", 32'sd32768, 32'sd32768,  32'sd0);
        it("loop_iter4", 32'sd32768, 32'sd32768,  32'sd0);
        it("loop_iter5", 32'sd32768, 32'sd32768,  32'sd0);

        // Derivative only.
        wr(32'd0, 32'sd0);
        wr(32'd1, 32'sd0);
        wr(32'd2, ONE);
        rst_pulse();
        it("kd_step",    32'sd32768, 32'sd0, 32'sd32768);
        it("kd_flat",    32'sd32768, 32'sd0, 32'sd0);
        it("kd_fall",    32'sd0,     32'sd0, -32'sd32768);
        // Asynchronous reset away from any clock edge.
        @(negedge clock);
        iterate_enable = 1'b0;
        chk_req        = 1'b0;
        reset          = 1'b0;
        #1 check("async_reset", out_clocked, 32'sd0);
        @(negedge clock);
        reset = 1'b1;
        it("kd_after_reset", 32'sd32768, 32'sd0, 32'sd32768);

        // Derivative saturation at both ends of the range.
        rst_pulse();
        it("kd_min_err", MINV, 32'sd1, MINV);
        it("kd_sat_max", MAXV, 32'sd0, MAXV);

        // Gains retained across reset; unmapped address ignored.
        wr(32'd0, ONE);
        wr(32'd1, ONE);
        wr(32'd2, 32'sd0);
        wr(32'd3, 32'sd5);
        wr(32'd7, 32'sd12345);
        rst_pulse();
        it("gain_bias", 32'sd1000, 32'sd0, 32'sd2005);
        rst_pulse();
        it("gain_retained", 32'sd1000, 32'sd0, 32'sd2005);

        // Write cycles and disabled iteration hold all state.
        hold("hold_write0", 1'b0, 1'b1, 32'sd77,  32'sd2005);
        hold("hold_write1", 1'b0, 1'b1, 32'sd154, 32'sd2005);
        hold("hold_write2", 1'b0, 1'b1, 32'sd231, 32'sd2005);
        hold("hold_idle0",  1'b1, 1'b0, 32'sd308, 32'sd2005);
        hold("hold_idle1",  1'b1, 1'b0, 32'sd385, 32'sd2005);
        it("integ_held", 32'sd1000, 32'sd0, 32'sd3005);

        // Error saturation at the negative limit.
        wr(32'd1, 32'sd0);
        wr(32'd3, 32'sd0);
        rst_pulse();
        it("err_sat_min", MINV, 32'sd1, MINV);

        // Large gain: output saturates or wraps depending on the build.
        wr(32'd0, MAXV);
        rst_pulse();
`ifdef PID_OUT_SATURATE_EN
        it("out_overflow", MAXV, 32'sd0, MAXV);
`else
        it("out_overflow", MAXV, 32'sd0, 32'shFFFE_0000);
`endif

        // Integrator pins at the positive limit and recovers without wrap.
        wr(32'd0, 32'sd0);
        wr(32'd1, ONE);
        rst_pulse();
        it("integ_pin1", MAXV, 32'sd0, MAXV);
        it("integ_pin2", MAXV, 32'sd0, MAXV);
        it("integ_pin3", MAXV, 32'sd0, MAXV);
        it("integ_unpin", 32'sd0, 32'sd1, 32'sh7FFF_FFFE);

        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected outputs never observed, required 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Discrete-time signed fixed-point PID controller with a registered output.
- Gains and an output bias are loaded through a simple active-low register-write port.
- Each enabled clock computes one PID iteration on error = target - measurement.
- Sits in the control loop between the sensor/measurement path and the actuator command.

Parameters:
- D_WIDTH, 32: width of data, gains, target, measurement and output. All are signed two's complement.
- FRAC_BITS, 15: fractional bits of the gain format. Default is Q(D_WIDTH-16).15, so 1<<15 = 1.0.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_enable  in  1  active-low register write strobe.
- iterate_enable  in  1  active-high; one PID iteration per qualified clock.
- reg_addr  in  D_WIDTH  register address.
- reg_data  in  D_WIDTH signed  register write data.
- target  in  D_WIDTH signed  setpoint.
- measurement  in  D_WIDTH signed  process feedback.
- out_clocked  out  D_WIDTH signed  registered controller output.

Behaviour:
- One clock domain; reset is asynchronous and active-low. Ports are named clock and reset.
- Register map, written on a rising edge when write_enable=0:
  - addr 0 = Kp
  - addr 1 = Ki
  - addr 2 = Kd
  - addr 3 = bias (output offset, integer scale, same Q format as output)
  - Other addresses: write ignored. There is no readback.
- Gain/bias registers are NOT cleared by reset; they hold their values across reset. They power up at 0 via register initialisation.
- Reset (reset=0) asynchronously clears integ, e_prev and out_clocked to 0.
- Iteration occurs on a rising edge when reset=1, write_enable=1 and iterate_enable=1:
  - e = target - measurement, computed in D_WIDTH+1 bits, then saturated to D_WIDTH.
  - integ_next = sat_D_WIDTH(integ + e).
  - d = sat_D_WIDTH(e - e_prev).
  - acc = Kp*e + Ki*integ_next + Kd*d. Products are 2*D_WIDTH bits; the sum is 2*D_WIDTH+2 bits.
  - y = (acc >>> FRAC_BITS) + bias, using arithmetic shift (truncation toward -inf).
  - Register updates: out_clocked <= y reduced to D_WIDTH (see Optional Feature); integ <= integ_next; e_prev <= e.
- Latency: out_clocked reflects the inputs sampled at the same edge, so it is valid one clock after the inputs are presented.
- Write cycle (write_enable=0): no iteration; integ, e_prev and out_clocked hold. The new gain takes effect from the next iteration.
- iterate_enable=0 (with write_enable=1): all state holds.
- Reset mid-operation: state clears immediately. The first iteration after release uses e_prev=0 and integ=0.
- Saturation limits are -2^(D_WIDTH-1) .. 2^(D_WIDTH-1)-1.

Optional Feature:
- Macro: PID_OUT_SATURATE_EN.
- Defined: y is saturated to the D_WIDTH signed range before being registered into out_clocked.
- Undefined: y is truncated to its low D_WIDTH bits, so it wraps on overflow.
- The integrator and derivative saturation described above applies in both cases.

Test Plan:
1. Write addr0=32768, addr1=32768, addr2=0, addr3=0, pulse reset low, then iterate with target=32768, measurement=65536 -> out_clocked=-65536.
2. Continue loop with measurement <= measurement + out_clocked each cycle:
   - Iteration 2 (measurement=0) -> out_clocked=32768.
   - Iteration 3 (measurement=32768) -> out_clocked=0.
   - Output stays 0 thereafter.
3. Kp=Ki=0, Kd=32768; e=+32768 for two iterations -> out_clocked=32768, then 0. Then reset low mid-run -> out_clocked=0 immediately, without waiting for a clock edge.
4. Gains loaded, then reset pulsed -> gains retained. Iteration with Kp=32768, e=1000 gives 1000 (+Ki term). Write to addr 7 changes nothing.
5. write_enable=0 and iterate_enable=0 hold: out_clocked and integ unchanged across 5 cycles with changing measurement.
6. Kp=0x7FFFFFFF, e=max positive:
   - With PID_OUT_SATURATE_EN -> out_clocked=0x7FFFFFFF.
   - Without it -> wrapped low bits.
   - Integrator pinned at 0x7FFFFFFF after repeated positive error.
